// File: rtl/add_tree_sat_pkg.sv
// Shared helpers for the saturating adder tree: width math, tree bus layout and the symmetric clamp.
package add_tree_sat_pkg;

    localparam int SAT_CNT_W = 16;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Clamp to +/-(2^(w-1)-1); the most negative code is deliberately excluded.
    function automatic logic signed [63:0] sat_limit(input logic signed [63:0] value,
                                                     input int w);
        logic signed [63:0] lim;
        lim = (64'sd1 <<< (w - 1)) - 64'sd1;
        if (value > lim) return lim;
        if (value < -lim) return -lim;
        return value;
    endfunction

    // Bit offset of tree level k inside the flattened bus; level i holds n>>i words of w+i bits.
    function automatic int level_off(input int n, input int w, input int k);
        int off;
        off = 0;
        for (int i = 0; i < k; i++) off += (n >> i) * (w + i);
        return off;
    endfunction

endpackage

// File: rtl/add_tree_level.sv
// One registered adder-tree level: M signed words of IW bits become M/2 words of IW+1 bits.
module add_tree_level import add_tree_sat_pkg::*; #(
    parameter int M  = 8,
    parameter int IW = 18
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clk_en,
    input  logic                       in_valid,
    input  logic [M*IW-1:0]            in_data,
    output logic                       out_valid,
    output logic [(M/2)*(IW+1)-1:0]    out_data
);

    logic [(M/2)*(IW+1)-1:0] sums;

    // Each operand is sign-extended by one bit so the pair sum cannot overflow.
    always_comb begin
        sums = '0;
        for (int j = 0; j < M / 2; j++) begin
            sums[j*(IW+1) +: IW+1] =
                {in_data[(2*j+1)*IW-1], in_data[2*j*IW +: IW]} +
                {in_data[(2*j+2)*IW-1], in_data[(2*j+1)*IW +: IW]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (clk_en) begin
            out_valid <= in_valid;
            out_data  <= sums;
        end
    end

endmodule

// File: rtl/add_tree_sat.sv
// Pipelined signed adder tree with symmetric saturation or wrap, plus sticky saturation status.
// Optional saturation event counter (satCount port) is built when ADD_TREE_SAT_STATS_EN is defined.
module add_tree_sat import add_tree_sat_pkg::*; #(
    parameter int N     = 8,
    parameter int W     = 18,
    parameter int LIMIT = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clkEn,
    input  logic                 validIn,
    input  logic [N*W-1:0]       din,
    input  logic                 clearSticky,
    output logic                 validOut,
    output logic [W-1:0]         sum,
    output logic                 satFlag,
    output logic                 satSticky
`ifdef ADD_TREE_SAT_STATS_EN
    ,
    output logic [SAT_CNT_W-1:0] satCount
`endif
);

    localparam int LG    = clog2(N);
    localparam int RW    = W + LG;
    localparam int BUS_W = level_off(N, W, LG + 1);

    logic [BUS_W-1:0]     tree;
    logic [LG:0]          vld;
    logic signed [RW-1:0] root;
    logic [W-1:0]         lim;
    logic                 sat;
    logic                 sat_event;

    assign tree[N*W-1:0] = din;
    assign vld[0]        = validIn;

    for (genvar k = 0; k < LG; k++) begin : g_level
        add_tree_level #(
            .M  (N >> k),
            .IW (W + k)
        ) u_level (
            .clk       (clk),
            .reset_n   (reset_n),
            .clk_en    (clkEn),
            .in_valid  (vld[k]),
            .in_data   (tree[level_off(N, W, k) +: (N >> k) * (W + k)]),
            .out_valid (vld[k+1]),
            .out_data  (tree[level_off(N, W, k + 1) +: (N >> (k + 1)) * (W + k + 1)])
        );
    end

    assign root = tree[level_off(N, W, LG) +: RW];

    if (LIMIT != 0) begin : g_sat
        logic signed [63:0] root_ext;
        logic signed [63:0] clamped;
        always_comb begin
            root_ext = 64'(root);
            clamped  = sat_limit(root_ext, W);
            lim      = clamped[W-1:0];
            sat      = (clamped != root_ext);
        end
    end else begin : g_wrap
        // Truncation changed the value when the dropped bits are not a sign extension.
        always_comb begin
            lim = root[W-1:0];
            sat = (root != {{LG{root[W-1]}}, root[W-1:0]});
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            validOut <= 1'b0;
            sum      <= '0;
            satFlag  <= 1'b0;
        end else if (clkEn) begin
            validOut <= vld[LG];
            sum      <= lim;
            satFlag  <= vld[LG] & sat;
        end
    end

    // An output counts once: on the enabled edge that retires it.
    assign sat_event = clkEn & validOut & satFlag;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            satSticky <= 1'b0;
        end else if (sat_event) begin
            satSticky <= 1'b1;
        end else if (clearSticky) begin
            satSticky <= 1'b0;
        end
    end

`ifdef ADD_TREE_SAT_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            satCount <= '0;
        end else if (clearSticky) begin
            satCount <= sat_event ? SAT_CNT_W'(1) : '0;
        end else if (sat_event && (satCount != {SAT_CNT_W{1'b1}})) begin
            satCount <= satCount + SAT_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_add_tree_sat.sv
// Scoreboard bench for add_tree_sat: a saturating (LIMIT=1) and a wrapping (LIMIT=0) instance share stimulus.
module tb_add_tree_sat;

    localparam int N    = 8;
    localparam int W    = 18;
    localparam int LG   = 3;
    localparam int L    = LG + 1;
    localparam int MAXV = (1 << (W - 1)) - 1;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           clkEn = 1'b0;
    logic           validIn = 1'b0;
    logic           clearSticky = 1'b0;
    logic [N*W-1:0] din = '0;

    logic           v1, f1, k1, v0, f0, k0;
    logic [W-1:0]   s1, s0;
`ifdef ADD_TREE_SAT_STATS_EN
    logic [15:0]    c1, c0;
`endif

    add_tree_sat #(.N(N), .W(W), .LIMIT(1)) dut (
        .clk(clk), .reset_n(reset_n), .clkEn(clkEn), .validIn(validIn), .din(din),
        .clearSticky(clearSticky), .validOut(v1), .sum(s1), .satFlag(f1), .satSticky(k1)
`ifdef ADD_TREE_SAT_STATS_EN
        , .satCount(c1)
`endif
    );

    add_tree_sat #(.N(N), .W(W), .LIMIT(0)) dut_wrap (
        .clk(clk), .reset_n(reset_n), .clkEn(clkEn), .validIn(validIn), .din(din),
        .clearSticky(clearSticky), .validOut(v0), .sum(s0), .satFlag(f0), .satSticky(k0)
`ifdef ADD_TREE_SAT_STATS_EN
        , .satCount(c0)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int           due;
        logic [W-1:0] sa;
        bit           fa;
        logic [W-1:0] sw;
        bit           fw;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   total = 0;
    int   bad = 0;
    int   ecnt = 0;
    bit   started = 0, last_adv = 0, last_rst = 0;
    bit   cur_v = 0, cur_known = 0;
    bit   stk_a = 0, stk_w = 0, ev_a, ev_w;
    int   cnt_a = 0, cnt_w = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: plain integer sum, then clamp or modulo-2^W.
    function automatic exp_t model(logic [N*W-1:0] d, int due);
        exp_t e;
        int s;
        int back;
        logic [W-1:0] t;
        s = 0;
        for (int k = 0; k < N; k++) begin
            t = d[k*W +: W];
            s += t[W-1] ? int'(t) - (1 << W) : int'(t);
        end
        e.due = due;
        if (s > MAXV) begin
            e.sa = W'(MAXV); e.fa = 1;
        end else if (s < -MAXV) begin
            e.sa = W'(-MAXV); e.fa = 1;
        end else begin
            e.sa = W'(s); e.fa = 0;
        end
        e.sw = W'(s);
        back = e.sw[W-1] ? int'(e.sw) - (1 << W) : int'(e.sw);
        e.fw = (back != s);
        return e;
    endfunction

    function automatic logic [N*W-1:0] fill(logic [W-1:0] x);
        return {N{x}};
    endfunction

    function automatic logic [N*W-1:0] rand_vec();
        logic [N*W-1:0] d;
        logic [W-1:0] t;
        for (int k = 0; k < N; k++) begin
            case ($urandom_range(0, 3))
                0: t = W'($urandom);
                1: t = W'(MAXV);
                2: t = W'(MAXV + 1);
                default: t = W'($urandom_range(0, 200) - 100);
            endcase
            d[k*W +: W] = t;
        end
        return d;
    endfunction

    task automatic drive(bit v, bit en, bit clr, logic [N*W-1:0] d);
        @(negedge clk);
        validIn = v; clkEn = en; clearSticky = clr; din = d;
        if (v && en && reset_n) q.push_back(model(d, ecnt + L));
    endtask

    task automatic do_reset(int cycles);
        @(negedge clk);
        reset_n = 0; validIn = 0; clkEn = 0; clearSticky = 0;
        repeat (cycles) @(posedge clk);
        #1 q.delete();
        @(negedge clk);
        reset_n = 1;
    endtask

    // Model of enabled-edge count and sticky/count status.
    always @(posedge clk) begin
        if (!reset_n) begin
            started <= 1; last_rst <= 1; last_adv <= 0;
            stk_a <= 0; stk_w <= 0; cnt_a <= 0; cnt_w <= 0;
        end else begin
            last_rst <= 0;
            last_adv <= clkEn;
            if (clkEn) ecnt <= ecnt + 1;
            ev_a = clkEn && cur_v && cur.fa;
            ev_w = clkEn && cur_v && cur.fw;
            if (ev_a) stk_a <= 1; else if (clearSticky) stk_a <= 0;
            if (ev_w) stk_w <= 1; else if (clearSticky) stk_w <= 0;
            if (clearSticky) cnt_a <= int'(ev_a);
            else if (ev_a && cnt_a < 65535) cnt_a <= cnt_a + 1;
            if (clearSticky) cnt_w <= int'(ev_w);
            else if (ev_w && cnt_w < 65535) cnt_w <= cnt_w + 1;
        end
    end

    // Monitor: decide what the output register must hold, pop from the scoreboard, compare.
    always @(negedge clk) begin
        if (started) begin
            if (last_rst) begin
                cur = '{default: 0};
                cur_v = 0;
                cur_known = 1;
            end else if (last_adv) begin
                while (q.size() > 0 && q[0].due < ecnt) begin
                    total++; bad++;
                    $display("FAIL lost_sample actual=none required=due%0d at %0t", q[0].due, $time);
                    void'(q.pop_front());
                end
                if (q.size() > 0 && q[0].due == ecnt) begin
                    cur = q.pop_front();
                    cur_v = 1;
                    cur_known = 1;
                end else begin
                    cur_v = 0;
                    cur_known = 0;
                end
            end
            check("validOut", 32'(v1), 32'(cur_v));
            check("validOut_wrap", 32'(v0), 32'(cur_v));
            check("satFlag", 32'(f1), 32'(cur_v ? cur.fa : 1'b0));
            check("satFlag_wrap", 32'(f0), 32'(cur_v ? cur.fw : 1'b0));
            if (cur_known) begin
                check("sum", 32'(s1), 32'(cur.sa));
                check("sum_wrap", 32'(s0), 32'(cur.sw));
            end
            check("satSticky", 32'(k1), 32'(stk_a));
            check("satSticky_wrap", 32'(k0), 32'(stk_w));
`ifdef ADD_TREE_SAT_STATS_EN
            check("satCount", 32'(c1), 32'(cnt_a));
            check("satCount_wrap", 32'(c0), 32'(cnt_w));
`endif
        end
    end

    initial begin
        logic [N*W-1:0] d;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1;

        // Saturation corners and the exact-max boundary, back to back.
        drive(1, 1, 0, fill(W'(MAXV)));
        drive(1, 1, 0, fill(W'(MAXV + 1)));
        d = '0;
        d[3*W +: W] = W'(MAXV + 1);
        drive(1, 1, 0, d);
        d = fill(W'(16384));
        d[5*W +: W] = W'(16383);
        drive(1, 1, 0, d);
        repeat (6) drive(0, 1, 0, '0);
        drive(0, 1, 1, '0);

        // Continuous samples with the enable toggling.
        for (int i = 0; i < 20; i++) drive(1, (i % 2) == 0, 0, rand_vec());
        repeat (6) drive(0, 1, 0, '0);

        // Three saturating samples in flight, then reset.
        repeat (3) drive(1, 1, 0, fill(W'(MAXV)));
        do_reset(1);
        repeat (2) drive(0, 1, 0, '0);

        // Wrap case, with clear held so it coincides with the saturation events.
        repeat (2) drive(1, 1, 0, fill(W'(18'h10000)));
        repeat (L) drive(0, 1, 1, '0);
        repeat (4) drive(0, 1, 0, '0);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                  $urandom_range(0, 19) == 0, rand_vec());
        end
        repeat (L + 4) drive(0, 1, 0, '0);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/add_tree_sat.md
ADD_TREE_SAT -- requirements
Module: add_tree_sat

Interface
REQ-001 SHALL have parameter N, default 8: number of signed inputs summed; power of two, 2..16.
REQ-002 SHALL have parameter W, default 18: width of each input and of the output.
REQ-003 SHALL have parameter LIMIT, default 1: 1 = saturate the output, 0 = wrap (keep the low W bits).
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port clkEn  input  1  pipeline advance enable.
REQ-007 SHALL have port validIn  input  1  din holds a sample this cycle.
REQ-008 SHALL have port din  input  N*W  packed signed two's-complement inputs; input k occupies bits [k*W+W-1 : k*W].
REQ-009 SHALL have port clearSticky  input  1  clears satSticky (and satCount when present).
REQ-010 SHALL have port validOut  output  1  sum is valid this cycle.
REQ-011 SHALL have port sum  output  W  limited or wrapped signed sum.
REQ-012 SHALL have port satFlag  output  1  this sum was saturated; qualified by validOut.
REQ-013 SHALL have port satSticky  output  1  a saturation has occurred since the last clear.
REQ-014 SHALL have port satCount  output  16  saturation event count; present only under ADD_TREE_SAT_STATS_EN.

Function
REQ-015 SHALL form the sum as a registered binary tree: log2(N) adder levels, each level registered, plus one output register holding the limit stage.
REQ-016 SHALL have latency L = log2(N)+1 enabled cycles from validIn to validOut (L=4 for N=8).
REQ-017 SHALL carry each sample's valid bit alongside its data through every stage.
REQ-018 SHALL sign-extend each level by one bit, giving full precision W+log2(N) at the root, so no intermediate overflow occurs.
REQ-019 SHALL, when LIMIT=1, clamp a root value > 2^(W-1)-1 to 2^(W-1)-1, and a root value < -(2^(W-1)-1), including -2^(W-1), to -(2^(W-1)-1) (symmetric range).
REQ-020 SHALL, when LIMIT=0, output root[W-1:0] and assert satFlag whenever that truncation changes the value.
REQ-021 SHALL, when clkEn=0, hold all pipeline registers, valid bits and outputs; validOut stays at its last value and SHALL NOT count as a new sample.
REQ-022 SHALL drive satFlag=0 whenever validOut=0.
REQ-023 SHALL set satSticky on any cycle where validOut=1, satFlag=1 and clkEn=1.
REQ-024 SHALL give set priority over clearSticky when both occur in the same cycle.
REQ-025 SHALL accept back-to-back samples every enabled cycle, with no bubbles inserted.

Reset
REQ-026 SHALL, while reset_n=0 at a clock edge, clear all valid bits, all pipeline data, sum, satFlag, satSticky and satCount to 0.
REQ-027 SHALL, on reset mid-stream, discard all in-flight samples; the first validOut follows a validIn sampled after reset_n rises, L enabled cycles later.
REQ-028 SHALL give reset priority over clkEn and clearSticky.

Configuration
REQ-029 SHALL, with macro ADD_TREE_SAT_STATS_EN defined, implement satCount: +1 per saturation event (REQ-023 condition), holding at 16'hFFFF; clearSticky zeroes it; a simultaneous event and clear yields 1.
REQ-030 SHALL, without ADD_TREE_SAT_STATS_EN, omit the satCount port and its logic entirely; all other behaviour is identical.

Structure
REQ-031 SHALL place in a shared package: function clog2; constant SAT_CNT_W=16; function sat_limit(value, W) returning the symmetric clamp.
REQ-032 SHALL use one sub-module, add_tree_level, for one registered tree level (M inputs of width IW to M/2 outputs of width IW+1, valid passthrough, clkEn hold), instantiated log2(N) times in a generate loop.

Verification
REQ-033 SHALL verify, with N=8, W=18, LIMIT=1: all din=18'h1FFFF -> 4 cycles later sum=18'h1FFFF, satFlag=1, satSticky=1.
REQ-034 SHALL verify: all din=18'h20000 -> sum=18'h20001, satFlag=1; and seven inputs 0 plus one input 18'h20000 -> sum=18'h20001, satFlag=1.
REQ-035 SHALL verify: inputs summing to exactly 131071 (e.g. 7x16384 + 16383) -> sum=18'h1FFFF, satFlag=0.
REQ-036 SHALL verify: continuous validIn with clkEn toggling 1,0,1,0 -> the output sequence matches the golden model with no loss or duplication, and validOut holds while clkEn=0.
REQ-037 SHALL verify: reset_n pulsed low with 3 samples in flight -> no validOut for those samples; satSticky=0 and satCount=0 afterward.
REQ-038 SHALL verify: LIMIT=0 with all din=18'h10000 -> sum=18'h0, satFlag=1; and, with the stats macro defined, clearSticky coincident with an event -> satCount=1, satSticky=1.
